// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter sharing one FIFO write port among N_REQ producers.
//   A granted producer may write up to BURST words back-to-back before
//   ownership rotates. The FIFO's full flag stalls writes without
//   dropping the grant.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   req        : per-producer "valid word on din slice"
//   din        : producer data, slice i = din[i*WIDTH +: WIDTH]
//   grant      : registered one-hot ownership, zero when idle
//   ack        : per-producer word-consumed strobe (grant & req & !fifo_full)
//   fifo_full  : full flag of the shared FIFO
//   fifo_write : FIFO write strobe (|ack)
//   fifo_din   : data of the granted producer, zero when idle
module fifo_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         ack,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_din
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(BURST + 1);

  localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(BURST - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t             state_r, state_n;
  logic [N_REQ-1:0]   grant_r, grant_n;
  logic [IW-1:0]      last_r, last_n;
  logic [CW-1:0]      cnt_r, cnt_n;

  logic [N_REQ-1:0]   ack_s;
  logic               owner_req_s;
  logic               owner_ack_s;
  logic               release_s;
  logic [IW-1:0]      owner_idx_s;
  logic [IW-1:0]      base_s;
  logic               win_found_s;
  logic [IW-1:0]      win_idx_s;
  logic [WIDTH-1:0]   fifo_din_s;

  // Per-producer acknowledge; the full flag gates every write combinationally.
  assign ack_s       = grant_r & req & {N_REQ{~fifo_full}};
  assign owner_req_s = |(grant_r & req);
  assign owner_ack_s = |ack_s;

  // A grant ends when the owner withdraws or its BURST-th word is accepted.
  assign release_s = (state_r == ST_OWN) &&
                     (!owner_req_s || (owner_ack_s && (cnt_r == CNT_LAST)));

  // Encode the one-hot grant into the owner index (grant is one-hot or zero).
  always_comb begin
    owner_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_idx_s = owner_idx_s | (grant_r[i] ? IW'(i) : '0);
    end
  end

  // Rotation base: the released owner when handing over, else the last owner.
  assign base_s = (state_r == ST_OWN) ? owner_idx_s : last_r;

  // Round-robin winner: rank 0 is base+1, rank N_REQ-1 is base itself,
  // so a sole requester can win again.
  always_comb begin
    int best_rank;
    int rank;
    best_rank   = N_REQ;
    rank        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rank = (i + N_REQ - 1 - int'(base_s)) % N_REQ;
      if (req[i] && (rank < best_rank)) begin
        best_rank   = rank;
        win_idx_s   = IW'(i);
        win_found_s = 1'b1;
      end else begin
        best_rank   = best_rank;
      end
    end
  end

  // Next-state logic for the IDLE/OWN ownership machine.
  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    last_n  = last_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_n = ST_OWN;
          grant_n = ONE_HOT0 << win_idx_s;
          cnt_n   = '0;
        end else begin
          state_n = ST_IDLE;
          grant_n = '0;
          cnt_n   = '0;
        end
      end
      ST_OWN: begin
        if (release_s) begin
          // Hand over in the same cycle so there is no bubble between owners.
          last_n = owner_idx_s;
          cnt_n  = '0;
          if (win_found_s) begin
            state_n = ST_OWN;
            grant_n = ONE_HOT0 << win_idx_s;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
          end
        end else if (owner_ack_s) begin
          cnt_n = cnt_r + CNT_ONE;
        end else begin
          // Stalled on full: hold grant and count.
          cnt_n = cnt_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        last_n  = LAST_RST;
        cnt_n   = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      last_r  <= LAST_RST;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
      cnt_r   <= cnt_n;
    end
  end

  // Data mux: AND-OR of the slices masked by the one-hot grant.
  always_comb begin
    fifo_din_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_din_s = fifo_din_s | (din[i*WIDTH +: WIDTH] & {WIDTH{grant_r[i]}});
    end
  end

  assign grant      = grant_r;
  assign ack        = ack_s;
  assign fifo_write = owner_ack_s;
  assign fifo_din   = fifo_din_s;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (N_REQ=4, WIDTH=8, BURST=4).
// Directed scenarios compare against hand-derived constants; a randomized
// phase compares against a behavioural ownership model.
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic [N-1:0]     grant;
  logic [N-1:0]     ack;
  logic             fifo_full;
  logic             fifo_write;
  logic [W-1:0]     fifo_din;

  int errors = 0;
  int checks = 0;

  // Behavioural model: owner index (-1 = idle), last owner, accepted writes.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .grant      (grant),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_din   (fifo_din)
  );

  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [N-1:0] v, input int idx);
    return |(v & (N'(1) << idx));
  endfunction

  function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] v, input int idx);
    return W'(v >> (idx * W));
  endfunction

  // First requester scanning base+1, base+2, ... with base itself last.
  function automatic int pick(input int base, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (bit_of(r, (base + k) % N)) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  function automatic logic [N-1:0] m_ack();
    return (m_owner >= 0 && bit_of(req, m_owner) && !fifo_full) ? m_grant() : '0;
  endfunction

  function automatic logic [W-1:0] m_din();
    return (m_owner < 0) ? '0 : slice_of(din, m_owner);
  endfunction

  task automatic model_tick();
    bit acc;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(m_last, req);
      m_cnt   = 0;
    end else begin
      acc = bit_of(req, m_owner) && !fifo_full;
      if (!bit_of(req, m_owner) || (acc && (m_cnt + 1 == B))) begin
        m_last  = m_owner;
        m_owner = pick(m_last, req);
        m_cnt   = 0;
      end else if (acc) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Advance one clock edge; the model sees the same pre-edge inputs as the DUT.
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    fifo_full = 1'b0;
    din = (N*W)'($urandom);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    fifo_full = 1'b0;
    din = (N*W)'($urandom);
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++;
      if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", fifo_write); end
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
    checks++;
    if (fifo_din !== din[7:0]) begin errors++; $display("FAIL reset_first_din: got %h want %h", fifo_din, din[7:0]); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k <= 20; k++) begin
      din = (N*W)'($urandom);
      exp_g = 4'b0001 << ((k / B) % N);
      @(negedge clk);
      checks++;
      if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_g); end
      checks++;
      if (fifo_write !== 1'b1) begin errors++; $display("FAIL rr_write[%0d]: got %b want 1", k, fifo_write); end
      checks++;
      if (fifo_din !== slice_of(din, (k / B) % N)) begin
        errors++; $display("FAIL rr_din[%0d]: got %h want %h", k, fifo_din, slice_of(din, (k / B) % N));
      end
      tick();
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || fifo_write !== 1'b1) begin
        errors++; $display("FAIL early_write[%0d]: got grant=%b write=%b want 0100/1", k, grant, fifo_write);
      end
      tick();
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (fifo_write !== 1'b0) begin errors++; $display("FAIL early_withdraw: got write=%b want 0", fifo_write); end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL early_idle: got %b want 0000", grant); end
    req = 4'b0101;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL early_next: got %b want 0001", grant); end
  endtask

  task automatic test_full_stall();
    do_reset();
    req = 4'b0010;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || fifo_write !== 1'b1) begin
      errors++; $display("FAIL stall_first: got grant=%b write=%b want 0010/1", grant, fifo_write);
    end
    tick();
    req = 4'b0011;
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0000 || fifo_write !== 1'b0 || grant !== 4'b0010) begin
        errors++; $display("FAIL stall_hold[%0d]: got ack=%b write=%b grant=%b want 0000/0/0010", k, ack, fifo_write, grant);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== 4'b0010 || grant !== 4'b0010) begin
        errors++; $display("FAIL stall_resume[%0d]: got ack=%b grant=%b want 0010/0010", k, ack, grant);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL stall_rotate: got %b want 0001", grant); end
  endtask

  task automatic test_sole_regrant();
    do_reset();
    req = 4'b1000;
    tick();
    for (int k = 0; k < 2 * B; k++) begin
      din = (N*W)'($urandom);
      @(negedge clk);
      checks++;
      if (grant !== 4'b1000 || fifo_write !== 1'b1 || fifo_din !== din[31:24]) begin
        errors++; $display("FAIL sole[%0d]: got grant=%b write=%b din=%h want 1000/1/%h", k, grant, fifo_write, fifo_din, din[31:24]);
      end
      tick();
    end
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || fifo_write !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: got grant=%b write=%b want 0000/0", grant, fifo_write);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_restart: got %b want 0001", grant); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = N'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      din       = (N*W)'($urandom);
      @(negedge clk);
      checks++;
      if (grant !== m_grant()) begin errors++; $display("FAIL rand_grant[%0d]: got %b want %b", k, grant, m_grant()); end
      checks++;
      if (ack !== m_ack()) begin errors++; $display("FAIL rand_ack[%0d]: got %b want %b", k, ack, m_ack()); end
      checks++;
      if (fifo_write !== (|m_ack())) begin errors++; $display("FAIL rand_write[%0d]: got %b want %b", k, fifo_write, |m_ack()); end
      checks++;
      if (fifo_din !== m_din()) begin errors++; $display("FAIL rand_din[%0d]: got %h want %h", k, fifo_din, m_din()); end
      checks++;
      if (fifo_full && fifo_write) begin errors++; $display("FAIL rand_full_write[%0d]: got write=1 want 0", k); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    fifo_full = 1'b0;
    test_reset();
    test_round_robin();
    test_early_release();
    test_full_stall();
    test_sole_regrant();
    test_mid_burst_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
